// File: rtl/matmul_pkg.sv
// Shared constants, bus types and APB register offsets for the matmul front-end.
package matmul_pkg;

  localparam int MAX_DIM     = 4;
  localparam int SP_NTARGETS = 4;
  localparam int DATA_WIDTH  = 8;
  localparam int BUS_WIDTH   = MAX_DIM * DATA_WIDTH;
  localparam int ADDR_WIDTH  = 16;

  typedef logic [BUS_WIDTH-1:0]                    data_bus_t;
  typedef logic [ADDR_WIDTH-1:0]                   adrr_bus_t;
  typedef logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]   elements_data_bus_t;

  // Register offsets decoded from paddr[4:0].
  localparam logic [4:0] CTRL_OFS  = 5'd0;
  localparam logic [4:0] OPA_OFS   = 5'd4;
  localparam logic [4:0] OPB_OFS   = 5'd8;
  localparam logic [4:0] FLAGS_OFS = 5'd12;
  localparam logic [4:0] SP_BASE   = 5'd16;

endpackage

// File: rtl/matmul_apb_regfile_scratchpad.sv
// Result scratchpad: NBANKS banks of NELEM words, one synchronous write port
// (core side) and one synchronous read port (APB side). A read and a write to
// the same word in one cycle return the old contents.
module matmul_apb_regfile_scratchpad #(
  parameter int NBANKS = matmul_pkg::SP_NTARGETS,
  parameter int NELEM  = matmul_pkg::MAX_DIM * matmul_pkg::MAX_DIM,
  parameter int WIDTH  = matmul_pkg::BUS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(NBANKS)-1:0] wr_bank,
  input  logic [$clog2(NELEM)-1:0]  wr_idx,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [$clog2(NBANKS)-1:0] rd_bank,
  input  logic [$clog2(NELEM)-1:0]  rd_idx,
  output logic [WIDTH-1:0]          rd_data
);
  import matmul_pkg::*;

  logic [WIDTH-1:0] mem_r [NBANKS][NELEM];
  logic [WIDTH-1:0] rd_data_r;

  // Storage array: cleared on reset, written by the core port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int e = 0; e < NELEM; e++) begin
          mem_r[b][e] <= '0;
        end
      end
    end else if (wr_en) begin
      mem_r[wr_bank][wr_idx] <= wr_data;
    end
  end

  // Read register: loaded only on a read so the value holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_bank][rd_idx];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/matmul_apb_regfile.sv
// APB slave front-end of the matmul accelerator: operand storage, control,
// start/busy/done sequencing, flag capture and banked result readback.
module matmul_apb_regfile #(
  parameter int DATA_WIDTH  = matmul_pkg::DATA_WIDTH,
  parameter int BUS_WIDTH   = matmul_pkg::BUS_WIDTH,
  parameter int ADDR_WIDTH  = matmul_pkg::ADDR_WIDTH,
  parameter int MAX_DIM     = matmul_pkg::MAX_DIM,
  parameter int SP_NTARGETS = matmul_pkg::SP_NTARGETS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    psel,
  input  logic                                    penable,
  input  logic                                    pwrite,
  input  logic [ADDR_WIDTH-1:0]                   paddr,
  input  logic [BUS_WIDTH-1:0]                    pwdata,
  input  logic [MAX_DIM-1:0]                      pstrb,
  output logic [BUS_WIDTH-1:0]                    prdata,
  output logic                                    done,
  output logic                                    start_o,
  output logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]   mat_a_o,
  output logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]   mat_b_o,
  input  logic                                    core_res_we_i,
  input  logic [$clog2(MAX_DIM*MAX_DIM)-1:0]      core_res_idx_i,
  input  logic [BUS_WIDTH-1:0]                    core_res_data_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]              core_flags_i,
  input  logic                                    core_done_i
);
  import matmul_pkg::*;

  localparam int NELEM = MAX_DIM * MAX_DIM;
  localparam int IW    = $clog2(NELEM);
  localparam int RW    = $clog2(MAX_DIM);
  localparam int BKW   = $clog2(SP_NTARGETS);

  logic                 access_s, wr_acc_s, rd_acc_s;
  logic [4:0]           ofs_s;
  logic [3:0]           elem_s;
  logic                 row_ok_s, sp_hit_s;
  logic                 ctrl_wr_s, start_req_s, opa_wr_s, opb_wr_s;
  logic [BUS_WIDTH-1:0] reg_rdata_s, reg_rdata_r, sp_rdata_s;
  logic                 sp_sel_r;
  logic [1:0]           ctrl_bank_r;
  logic                 busy_r, done_r, start_r;
  logic [NELEM-1:0]     flags_r;
  logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] mat_a_r, mat_b_r;
  logic                 unused_addr_s;

  assign access_s = psel & penable;
  assign wr_acc_s = access_s & pwrite;
  assign rd_acc_s = access_s & ~pwrite;
  assign ofs_s    = paddr[4:0];
  assign elem_s   = paddr[8:5];
  assign row_ok_s = (int'(elem_s) < MAX_DIM);
  // Scratchpad words sit at 16, 20, 24, 28; misaligned offsets decode as unmapped.
  assign sp_hit_s = ofs_s[4] & (ofs_s[1:0] == 2'b00);
  assign unused_addr_s = ^paddr[ADDR_WIDTH-1:9];

  // While busy, control and operand writes are dropped; a start that meets
  // core completion in the same cycle is dropped as well.
  assign ctrl_wr_s   = wr_acc_s & (ofs_s == CTRL_OFS) & ~busy_r;
  assign start_req_s = ctrl_wr_s & pwdata[0] & ~core_done_i;
  assign opa_wr_s    = wr_acc_s & (ofs_s == OPA_OFS) & ~busy_r & row_ok_s;
  assign opb_wr_s    = wr_acc_s & (ofs_s == OPB_OFS) & ~busy_r & row_ok_s;

  // Register-side read mux; start bit always reads back as zero.
  always_comb begin
    reg_rdata_s = '0;
    case (ofs_s)
      CTRL_OFS:  reg_rdata_s = BUS_WIDTH'({ctrl_bank_r, 2'b00});
      FLAGS_OFS: reg_rdata_s = BUS_WIDTH'(flags_r);
      default:   reg_rdata_s = '0;
    endcase
  end

  // Control state: target bank, start pulse, busy/done handshake and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_bank_r <= 2'b00;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      flags_r     <= '0;
    end else begin
      start_r <= start_req_s;
      if (ctrl_wr_s) begin
        ctrl_bank_r <= pwdata[3:2];
      end
      if (core_done_i) begin
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
        flags_r <= core_flags_i;
      end else if (start_req_s) begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end
  end

  // Operand matrices: per-element strobed row writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_a_r <= '0;
      mat_b_r <= '0;
    end else begin
      for (int k = 0; k < MAX_DIM; k++) begin
        if (opa_wr_s && pstrb[k]) begin
          mat_a_r[elem_s[RW-1:0]][k] <= pwdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (opb_wr_s && pstrb[k]) begin
          mat_b_r[elem_s[RW-1:0]][k] <= pwdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read-data capture: both sources only change on a read access.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rdata_r <= '0;
      sp_sel_r    <= 1'b0;
    end else if (rd_acc_s) begin
      reg_rdata_r <= reg_rdata_s;
      sp_sel_r    <= sp_hit_s;
    end
  end

  matmul_apb_regfile_scratchpad #(
    .NBANKS (SP_NTARGETS),
    .NELEM  (NELEM),
    .WIDTH  (BUS_WIDTH)
  ) u_scratchpad (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (core_res_we_i & busy_r),
    .wr_bank (ctrl_bank_r[BKW-1:0]),
    .wr_idx  (core_res_idx_i),
    .wr_data (core_res_data_i),
    .rd_en   (rd_acc_s & sp_hit_s),
    .rd_bank (paddr[2 +: BKW]),
    .rd_idx  (elem_s[IW-1:0]),
    .rd_data (sp_rdata_s)
  );

  assign prdata  = sp_sel_r ? sp_rdata_s : reg_rdata_r;
  assign done    = done_r;
  assign start_o = start_r;
  assign mat_a_o = mat_a_r;
  assign mat_b_o = mat_b_r;

endmodule

// File: tb/tb_matmul_apb_regfile.sv
// Directed self-checking bench for matmul_apb_regfile.
module tb_matmul_apb_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel, penable, pwrite;
  logic [15:0]  paddr;
  logic [31:0]  pwdata, prdata;
  logic [3:0]   pstrb;
  logic         done, start_o;
  logic [127:0] mat_a_o, mat_b_o;
  logic         core_res_we_i;
  logic [3:0]   core_res_idx_i;
  logic [31:0]  core_res_data_i;
  logic [15:0]  core_flags_i;
  logic         core_done_i;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  logic [31:0] rd;

  matmul_apb_regfile dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
    .done(done), .start_o(start_o), .mat_a_o(mat_a_o), .mat_b_o(mat_b_o),
    .core_res_we_i(core_res_we_i), .core_res_idx_i(core_res_idx_i),
    .core_res_data_i(core_res_data_i), .core_flags_i(core_flags_i),
    .core_done_i(core_done_i)
  );

  always #5 clk = ~clk;

  // Count start pulses seen on rising edges.
  always @(posedge clk) begin
    if (start_o) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] sp_addr(input int bank, input int elem);
    return 16'(elem * 32 + 16 + bank * 4);
  endfunction

  function automatic logic [15:0] row_addr(input int row, input int ofs);
    return 16'(row * 32 + ofs);
  endfunction

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    d = prdata;
  endtask

  task automatic core_write(input int idx, input logic [31:0] d);
    @(negedge clk);
    core_res_we_i = 1'b1; core_res_idx_i = 4'(idx); core_res_data_i = d;
    @(negedge clk);
    core_res_we_i = 1'b0;
  endtask

  task automatic core_finish(input logic [15:0] f);
    @(negedge clk);
    core_done_i = 1'b1; core_flags_i = f;
    @(negedge clk);
    core_done_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0;
    pwdata = 32'h0; pstrb = 4'h0; core_res_we_i = 1'b0; core_res_idx_i = 4'h0;
    core_res_data_i = 32'h0; core_flags_i = 16'h0; core_done_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_done", 32'(done), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    apb_read(row_addr(0, 0), rd);  check("rst_ctrl", rd, 32'h0);
    apb_read(row_addr(0, 12), rd); check("rst_flags", rd, 32'h0);
    apb_read(sp_addr(0, 5), rd);   check("rst_sp0_5", rd, 32'h0);

    // Core write while idle is dropped
    core_write(3, 32'd55);
    apb_read(sp_addr(0, 3), rd);   check("idle_core_wr", rd, 32'h0);

    // Strobed operand row write, then out-of-range row
    apb_write(row_addr(1, 4), 32'h04030201, 4'b0101);
    check("opa_row1", mat_a_o[63:32], 32'h00030001);
    apb_write(row_addr(4, 4), 32'hFFFFFFFF, 4'hF);
    check("opa_row4_r0", mat_a_o[31:0], 32'h0);
    check("opa_row4_r1", mat_a_o[63:32], 32'h00030001);
    check("opa_row4_hi", mat_a_o[127:96] | mat_a_o[95:64], 32'h0);
    apb_read(row_addr(0, 2), rd);  check("unmapped", rd, 32'h0);
    check("no_start_yet", 32'(start_cnt), 32'd0);

    // Start into bank 2
    apb_write(row_addr(0, 0), 32'h9, 4'hF);
    check("start1_hi", 32'(start_o), 32'h1);
    @(negedge clk);
    check("start1_lo", 32'(start_o), 32'h0);
    check("start1_cnt", 32'(start_cnt), 32'd1);
    apb_read(row_addr(0, 0), rd);  check("ctrl_bank2", rd, 32'h8);

    // Writes while busy are ignored
    apb_write(row_addr(0, 8), 32'hFFFFFFFF, 4'hF);
    check("busy_opb", mat_b_o[31:0], 32'h0);
    apb_write(row_addr(0, 0), 32'h5, 4'hF);
    @(negedge clk);
    check("busy_start_cnt", 32'(start_cnt), 32'd1);
    apb_read(row_addr(0, 0), rd);  check("busy_ctrl", rd, 32'h8);

    // Core fills bank 2 and completes
    for (int i = 0; i < 16; i++) core_write(i, 32'(100 + i));
    check("done_before", 32'(done), 32'h0);
    core_finish(16'h8001);
    check("done_after", 32'(done), 32'h1);
    apb_read(sp_addr(2, 3), rd);   check("sp2_3", rd, 32'd103);
    apb_read(sp_addr(2, 15), rd);  check("sp2_15", rd, 32'd115);
    apb_read(sp_addr(0, 3), rd);   check("sp0_3", rd, 32'h0);
    apb_read(row_addr(0, 12), rd); check("flags", rd, 32'h00008001);

    // Restart into bank 1: done clears as start rises
    apb_write(row_addr(0, 0), 32'h5, 4'hF);
    check("start2_hi", 32'(start_o), 32'h1);
    check("start2_done", 32'(done), 32'h0);

    // Read-before-write on the same scratchpad word
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = sp_addr(1, 3);
    @(negedge clk);
    penable = 1'b1;
    core_res_we_i = 1'b1; core_res_idx_i = 4'd3; core_res_data_i = 32'd200;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; core_res_we_i = 1'b0;
    check("rbw_old", prdata, 32'h0);
    apb_read(sp_addr(1, 3), rd);   check("rbw_new", rd, 32'd200);
    apb_read(sp_addr(2, 3), rd);   check("sp2_kept", rd, 32'd103);
    core_finish(16'h0001);
    check("done2", 32'(done), 32'h1);
    apb_read(row_addr(0, 12), rd); check("flags2", rd, 32'h00000001);
    check("start2_cnt", 32'(start_cnt), 32'd2);

    // Start into bank 0, then reset mid-operation
    apb_write(row_addr(0, 0), 32'h1, 4'hF);
    core_write(0, 32'd77);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_prdata", prdata, 32'h0);
    check("mid_rst_start", 32'(start_o), 32'h0);
    check("mid_rst_mata", mat_a_o[63:32], 32'h0);
    core_write(0, 32'd99);
    for (int b = 0; b < 4; b++) begin
      apb_read(sp_addr(b, 3), rd);  check($sformatf("rst_bank%0d_3", b), rd, 32'h0);
    end
    apb_read(sp_addr(0, 0), rd);   check("rst_core_ignored", rd, 32'h0);
    apb_read(row_addr(0, 12), rd); check("rst_flags2", rd, 32'h0);
    apb_write(row_addr(0, 8), 32'h11223344, 4'hF);
    check("rst_not_busy", mat_b_o[31:0], 32'h11223344);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul_apb_regfile.md
Name: matmul_apb_regfile

Overview:
- APB slave front-end of the matmul accelerator.
- Decodes APB transfers from the bus master (test stimulus or SoC):
  - stores operand matrices A and B,
  - holds the control register,
  - issues a one-cycle start pulse to the compute core,
  - banks core results into a 4-bank scratchpad,
  - returns results, flags and control over prdata.
- Sits directly between the APB master and the matmul compute core.

Parameters:
- DATA_WIDTH, 8: operand element width.
- BUS_WIDTH, 32: pwdata/prdata width; must equal MAX_DIM*DATA_WIDTH.
- ADDR_WIDTH, 16: paddr width.
- MAX_DIM, 4: matrix dimension (square, MAX_DIM x MAX_DIM).
- SP_NTARGETS, 4: number of scratchpad result banks.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  BUS_WIDTH  write data; element k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- pstrb  in  MAX_DIM  per-element write strobe.
- prdata  out  BUS_WIDTH  registered read data.
- done  out  1  operation complete, sticky.
- start_o  out  1  one-cycle start pulse to core.
- mat_a_o  out  MAX_DIM*MAX_DIM*DATA_WIDTH  flattened A, row-major.
- mat_b_o  out  MAX_DIM*MAX_DIM*DATA_WIDTH  flattened B, row-major.
- core_res_we_i  in  1  core result element write.
- core_res_idx_i  in  $clog2(MAX_DIM**2)  element index, r*MAX_DIM+c.
- core_res_data_i  in  BUS_WIDTH  result element.
- core_flags_i  in  MAX_DIM**2  per-element overflow flags, valid with core_done_i.
- core_done_i  in  1  one-cycle core completion pulse.

Behaviour:
- Access fires on the cycle where psel & penable are both 1. There are no wait states.
- Address map on paddr[4:0]; element/row index on paddr[8:5].
  - 0 = CTRL (RW).
    - bit0 start: write-1 generates start_o, reads as 0.
    - bits[3:2]: result target bank.
    - other bits reserved, read 0.
  - 4 = OPA row write.
  - 8 = OPB row write.
  - 12 = FLAGS (RO), zero-extended.
  - 16+4*b = scratchpad bank b (RO), b = paddr[3:2].
  - Any other offset: reads 0, writes ignored.
- OPA/OPB row write:
  - Row = paddr[8:5]; element k is updated only where pstrb[k]=1.
  - Row >= MAX_DIM: write ignored.
- Scratchpad read: element = paddr[8:5]; index >= MAX_DIM**2 reads 0.
- prdata:
  - Loaded on the read access cycle.
  - Valid from the following cycle and held until the next read access.
  - Write accesses do not change prdata.
- start_o:
  - Asserted the cycle after a CTRL write with pwdata[0]=1 while not busy.
  - The same write updates CTRL bits[3:2] first, so the core writes to the new bank.
- busy:
  - Set with start_o; cleared on core_done_i.
  - While busy, writes to CTRL/OPA/OPB are ignored. Reads are always serviced.
- done:
  - Cleared on the cycle start_o asserts.
  - Set the cycle after core_done_i; stays 1 until the next accepted start.
- On core_done_i, FLAGS captures core_flags_i.
- core_res_we_i writes core_res_data_i into bank CTRL[3:2] at core_res_idx_i.
  - Ignored when not busy.
- Simultaneous core_res_we_i and APB read of the same element: prdata returns the old value (read-before-write).
- core_done_i and a CTRL start write in the same cycle: done is set, busy clears; the start is ignored.
- Reset values:
  - prdata, done, start_o, busy, CTRL, FLAGS: 0.
  - A, B and all scratchpad banks: 0.
- Reset asserted mid-operation aborts it: busy=0, done=0, and any subsequent core writes are ignored.

Decomposition:
- matmul_pkg carries:
  - MAX_DIM, SP_NTARGETS, DATA_WIDTH, BUS_WIDTH;
  - data_bus_t, adrr_bus_t, elements_data_bus_t;
  - the address offsets CTRL/OPA/OPB/FLAGS/SP_BASE as localparams.
- Sub-module matmul_scratchpad: SP_NTARGETS x MAX_DIM**2 x BUS_WIDTH storage.
  - One write port (core) and one read port (APB), both synchronous.

Test Plan:
- Reset, then read CTRL, FLAGS and bank 0 element 5 -> prdata=0 each time; done=0, start_o never pulses.
- Write OPA row 1 with pwdata=32'h04030201, pstrb=4'b0101 -> mat_a_o row 1 elements = {0,3,0,1}. Then write row 4 -> no change.
- Write CTRL=32'h9 (bank 2, start) -> start_o high exactly 1 cycle. Then:
  - core writes idx 0..15 with values 100..115 and pulses core_done_i with flags 16'h8001;
  - expect done=1 the next cycle;
  - SP bank 2 element 3 reads 103; FLAGS reads 32'h8001.
- While busy, write OPB row 0 = 32'hFFFFFFFF with pstrb=4'hF -> mat_b_o unchanged. A second start write -> no start_o.
- After done, write CTRL=32'h5 -> done clears the same cycle start_o rises. Bank 1 is written; bank 2 values are preserved.
- Assert rst mid-operation, then apply a core_res_we_i pulse -> busy=0, done=0, all banks read 0.
